// File: rtl/rst_seq.sv
// rst_seq: async-assert, synchronized and staggered release of a bank of active-low resets
module rst_seq #(
    parameter int SYNC_DEPTH  = 2,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic               dst_clk,
    input  logic               src_rst_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] dst_rst_n,
    output logic               rst_done
);
    localparam int SW   = SYNC_DEPTH - 1;
    localparam int MAXC = HOLD_CYCLES > STEP_CYCLES ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW   = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] LAST    = IW'(NUM_OUT - 1);

    typedef enum logic [1:0] {RESET, HOLD, STEP, DONE} state_t;

    state_t          state;
    logic [SW-1:0]   sync_q;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;

    // The state register's RESET->HOLD transition acts as the last synchronizer stage
    always_ff @(posedge dst_clk or negedge src_rst_n)
        if (!src_rst_n) sync_q <= '0;
        else            sync_q <= SW'({sync_q, 1'b1});

    always_ff @(posedge dst_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state     <= RESET;
            cnt       <= HOLD_LD;
            idx       <= '0;
            dst_rst_n <= '0;
            rst_done  <= 1'b0;
        end else if (state != RESET && soft_rst_req) begin
            state     <= HOLD;
            cnt       <= HOLD_LD;
            dst_rst_n <= '0;
            rst_done  <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    cnt <= HOLD_LD;
                    if (sync_q[SW-1]) state <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        dst_rst_n <= NUM_OUT'({dst_rst_n, 1'b1});
                        idx       <= IW'(1);
                        cnt       <= STEP_LD;
                        state     <= NUM_OUT == 1 ? DONE : STEP;
                        rst_done  <= NUM_OUT == 1;
                    end else cnt <= cnt - CW'(1);
                end
                STEP: begin
                    if (cnt == '0) begin
                        dst_rst_n <= NUM_OUT'({dst_rst_n, 1'b1});
                        idx       <= idx + IW'(1);
                        cnt       <= STEP_LD;
                        state     <= idx == LAST ? DONE : STEP;
                        rst_done  <= idx == LAST;
                    end else cnt <= cnt - CW'(1);
                end
                default: begin
                    dst_rst_n <= '1;
                    rst_done  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed timeline checks of rst_seq release timing, soft reset and async abort
module tb_rst_seq;
    logic       dst_clk;
    logic       src_rst_n, soft_rst_req;
    logic [2:0] dst_rst_n;
    logic       rst_done;
    logic       src_rst2_n, soft2;
    logic [0:0] dst2;
    logic       done2;
    int         n_cmp, n_err;

    rst_seq dut (
        .dst_clk(dst_clk), .src_rst_n(src_rst_n), .soft_rst_req(soft_rst_req),
        .dst_rst_n(dst_rst_n), .rst_done(rst_done)
    );

    rst_seq #(.SYNC_DEPTH(3), .NUM_OUT(1), .HOLD_CYCLES(1), .STEP_CYCLES(4)) dut2 (
        .dst_clk(dst_clk), .src_rst_n(src_rst2_n), .soft_rst_req(soft2),
        .dst_rst_n(dst2), .rst_done(done2)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    task automatic wait_until(input longint t);
        #(t - longint'($time));
    endtask

    // edge k is the posedge at 10k+5; sample 1 unit later
    task automatic at_edge(input int k);
        wait_until(longint'(10 * k + 6));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [2:0] o, input logic d);
        chk({tag, ".out"}, 32'(dst_rst_n), 32'(o));
        chk({tag, ".done"}, 32'(rst_done), 32'(d));
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        src_rst_n = 1'b0; soft_rst_req = 1'b0;
        src_rst2_n = 1'b0; soft2 = 1'b0;
        wait_until(2);
        chk_main("reset", 3'b000, 1'b0);
        chk("reset2", 32'({dst2, done2}), 32'h0);
        wait_until(10);
        src_rst_n = 1'b1;
        at_edge(17); chk_main("e17", 3'b000, 1'b0);
        at_edge(18); chk_main("e18", 3'b001, 1'b0);
        at_edge(21); chk_main("e21", 3'b001, 1'b0);
        at_edge(22); chk_main("e22", 3'b011, 1'b0);
        at_edge(25); chk_main("e25", 3'b011, 1'b0);
        at_edge(26); chk_main("e26", 3'b111, 1'b1);
        wait_until(308);
        src_rst_n = 1'b0;
        wait_until(310); chk_main("async_done", 3'b000, 1'b0);
        wait_until(322);
        src_rst_n = 1'b1;
        at_edge(48); chk_main("r48", 3'b000, 1'b0);
        at_edge(49); chk_main("r49", 3'b001, 1'b0);
        at_edge(53); chk_main("r53", 3'b011, 1'b0);
        at_edge(56); chk_main("r56", 3'b011, 1'b0);
        at_edge(57); chk_main("r57", 3'b111, 1'b1);
        at_edge(99);
        soft_rst_req = 1'b1;
        at_edge(100);
        soft_rst_req = 1'b0;
        chk_main("s100", 3'b000, 1'b0);
        at_edge(115); chk_main("s115", 3'b000, 1'b0);
        at_edge(116); chk_main("s116", 3'b001, 1'b0);
        at_edge(120); chk_main("s120", 3'b011, 1'b0);
        at_edge(123); chk_main("s123", 3'b011, 1'b0);
        at_edge(124); chk_main("s124", 3'b111, 1'b1);
        at_edge(199);
        soft_rst_req = 1'b1;
        at_edge(204); chk_main("h204", 3'b000, 1'b0);
        at_edge(209);
        soft_rst_req = 1'b0;
        at_edge(224); chk_main("h224", 3'b000, 1'b0);
        at_edge(225); chk_main("h225", 3'b001, 1'b0);
        at_edge(229); chk_main("h229", 3'b011, 1'b0);
        at_edge(233); chk_main("h233", 3'b111, 1'b1);
        at_edge(235);
        soft_rst_req = 1'b1;
        at_edge(236);
        soft_rst_req = 1'b0;
        at_edge(252); chk_main("p252", 3'b001, 1'b0);
        wait_until(2527);
        src_rst_n = 1'b0;
        wait_until(2529); chk_main("glitch", 3'b000, 1'b0);
        wait_until(2530);
        src_rst_n = 1'b1;
        at_edge(253); chk_main("g253", 3'b000, 1'b0);
        at_edge(269); chk_main("g269", 3'b000, 1'b0);
        at_edge(270); chk_main("g270", 3'b001, 1'b0);
        at_edge(274); chk_main("g274", 3'b011, 1'b0);
        at_edge(278); chk_main("g278", 3'b111, 1'b1);
        wait_until(2900);
        soft2 = 1'b1;
        wait_until(2912);
        src_rst2_n = 1'b1;
        at_edge(292);
        chk("n1_e292", 32'({dst2, done2}), 32'h0);
        soft2 = 1'b0;
        at_edge(293); chk("n1_e293", 32'({dst2, done2}), 32'h0);
        at_edge(294); chk("n1_e294", 32'({dst2, done2}), 32'h3);
        at_edge(300); chk("n1_e300", 32'({dst2, done2}), 32'h3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset release sequencer for the dst_clk domain.
- Asynchronously asserts a bank of active-low resets from src_rst_n.
- Synchronizes the release internally, holds all resets for a minimum time, then releases the outputs one by one in a fixed order with a programmable gap between them.
- Supports a synchronous soft-reset request that re-runs the full sequence; sits between the board/system reset and multi-stage datapaths (e.g. PHY before MAC before user logic).

Parameters:
- SYNC_DEPTH, 2: synchronizer flop count for src_rst_n deassertion; legal range >= 2.
- NUM_OUT, 3: number of sequenced reset outputs; legal range >= 1.
- HOLD_CYCLES, 16: dst_clk cycles from synchronized release (or soft request) to release of output 0; legal range >= 1.
- STEP_CYCLES, 4: dst_clk cycles between releases of consecutive outputs; legal range >= 1.

Ports:
- dst_clk  input  1  destination clock.
- src_rst_n  input  1  reset, asynchronous, active-low; clock dst_clk. Asynchronous to dst_clk at the source.
- soft_rst_req  input  1  dst_clk-synchronous soft-reset request, level-sampled each edge.
- dst_rst_n  output  NUM_OUT  sequenced active-low resets; bit 0 is released first.
- rst_done  output  1  high once all dst_rst_n bits are released.

Behaviour:
- Assertion:
  - src_rst_n low forces every dst_rst_n bit to 0, rst_done to 0, the synchronizer chain to 0 and the FSM to RESET immediately, with no clock needed.
  - All flops use async reset on src_rst_n.
- Synchronizer:
  - SYNC_DEPTH-flop shift chain shifting in 1.
  - Define T0 as the SYNC_DEPTH-th dst_clk rising edge after src_rst_n rises, i.e. the first edge at which the chain output is 1.
- FSM states RESET, HOLD, STEP, DONE.
- RESET:
  - Outputs all 0, rst_done 0, and the counter loads HOLD_CYCLES-1.
  - Go to HOLD at T0.
- HOLD:
  - The counter decrements each edge.
  - On the edge where it reaches 0, set dst_rst_n[0]=1.
  - If NUM_OUT==1, go to DONE; else load STEP_CYCLES-1, set index=1 and go to STEP.
- STEP:
  - The counter decrements.
  - At 0, set dst_rst_n[index]=1.
  - If index==NUM_OUT-1, go to DONE; else increment index and reload.
- DONE:
  - rst_done=1, all outputs 1, holds indefinitely.
- Required release timing, all as registered outputs:
  - dst_rst_n[k] rises at edge T0+HOLD_CYCLES+k*STEP_CYCLES.
  - rst_done rises at the same edge as dst_rst_n[NUM_OUT-1].
  - Released bits stay 1 until the next reset or soft request.
- Soft reset:
  - soft_rst_req sampled 1 at edge S while in HOLD, STEP or DONE: at edge S all dst_rst_n bits go to 0, rst_done goes to 0, the counter loads HOLD_CYCLES-1 and the FSM enters HOLD.
  - Release then follows the timing formula with T0 replaced by S.
  - soft_rst_req held high restarts the sequence on every edge, so outputs stay 0; timing is measured from the last edge sampled high.
  - soft_rst_req is ignored in RESET.
- Simultaneous events:
  - src_rst_n low dominates everything.
  - soft_rst_req on the same edge a bit would release takes priority; no bit releases.
- Reset mid-sequence:
  - src_rst_n low during HOLD or STEP aborts immediately to RESET with all outputs 0.
  - A src_rst_n low pulse shorter than one dst_clk period still asserts all outputs and forces a full resequence.
- Output invariants:
  - dst_rst_n is always thermometer-coded: bit k set implies bits 0..k-1 set.
  - No output glitches on release: each bit is driven directly from its own flop.
- Counter width is $clog2(max(HOLD_CYCLES,STEP_CYCLES)) (minimum 1). Index width is $clog2(NUM_OUT) (minimum 1).

Test Plan:
- Defaults; src_rst_n rises between edges 0 and 1 -> T0=edge 2; dst_rst_n goes 001 at edge 18, 011 at edge 22, 111 at edge 26; rst_done=1 at edge 26.
- In DONE, drive src_rst_n low mid-cycle -> dst_rst_n=000 and rst_done=0 before the next edge; raise src_rst_n again -> same release timeline relative to the new T0.
- Defaults; soft_rst_req high for 1 cycle at edge S=100 in DONE -> outputs 000 at edge 100; 001 at 116, 011 at 120, 111 at 124.
- soft_rst_req held high for edges 100..109 -> outputs stay 000; release at 125, 129 and 133.
- src_rst_n low for 3 ns (< one period) during STEP with dst_rst_n=001 -> immediate 000, FSM to RESET, full sequence replays from the new T0.
- NUM_OUT=1, HOLD_CYCLES=1, SYNC_DEPTH=3 -> dst_rst_n[0] and rst_done rise at edge T0+1 (4th edge after release); soft_rst_req asserted in RESET has no effect.
